// File: rtl/fifo_rd_packer.sv
// Read-side packer for an async FIFO: pops DSIZE-bit words and packs RATIO of them
// into one wide beat on a valid/ready stream, with flush support for partial beats.
module fifo_rd_packer #(
    parameter int DSIZE = 8,
    parameter int RATIO = 4,
    parameter int CNTW  = 4
) (
    input  logic                     rclk,
    input  logic                     rrst,
    input  logic [DSIZE-1:0]         fifo_rdata,
    input  logic                     fifo_rempty,
    output logic                     fifo_rinc,
    input  logic                     flush,
    output logic [DSIZE*RATIO-1:0]   out_data,
    output logic [CNTW-1:0]          out_words,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(RATIO);
    localparam logic [CNTW-1:0] ZERO_CNT = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] ONE_CNT  = {{(CNTW-1){1'b0}}, 1'b1};

    logic [CNTW-1:0]               acc_cnt_q, acc_cnt_d;
    logic [RATIO-1:0][DSIZE-1:0]   acc_q, acc_d;
    logic                          flush_pend_q, flush_pend_d;
    logic [DSIZE*RATIO-1:0]        out_data_q, out_data_d;
    logic [CNTW-1:0]               out_words_q, out_words_d;
    logic                          out_valid_q, out_valid_d;

    logic                          acc_full_s;
    logic                          out_free_s;
    logic                          xfer_s;
    logic                          pop_s;
    logic [CNTW-1:0]               wr_idx_s;
    logic [DSIZE*RATIO-1:0]        beat_s;

    // Transfer/pop decisions; a pop in the same cycle as a transfer refills lane 0
    always_comb begin
        acc_full_s = (acc_cnt_q == FULL_CNT);
        out_free_s = !out_valid_q || out_ready;
        xfer_s     = out_free_s && (acc_full_s || (flush_pend_q && (acc_cnt_q != ZERO_CNT)));
        pop_s      = !rrst && !fifo_rempty && !flush_pend_q && !flush &&
                     ((acc_cnt_q < FULL_CNT) || xfer_s);
        if (xfer_s) begin
            wr_idx_s = ZERO_CNT;
        end else begin
            wr_idx_s = acc_cnt_q;
        end
    end

    // Beat image with lanes beyond the fill count zeroed so stale words never leak out
    always_comb begin
        beat_s = {(DSIZE*RATIO){1'b0}};
        for (int k = 0; k < RATIO; k++) begin
            if (CNTW'(k) < acc_cnt_q) begin
                beat_s[k*DSIZE +: DSIZE] = acc_q[k];
            end else begin
                beat_s[k*DSIZE +: DSIZE] = {DSIZE{1'b0}};
            end
        end
    end

    // Accumulator lanes and fill count
    always_comb begin
        acc_d = acc_q;
        for (int k = 0; k < RATIO; k++) begin
            if (pop_s && (wr_idx_s == CNTW'(k))) begin
                acc_d[k] = fifo_rdata;
            end else begin
                acc_d[k] = acc_q[k];
            end
        end
        if (xfer_s) begin
            acc_cnt_d = pop_s ? ONE_CNT : ZERO_CNT;
        end else if (pop_s) begin
            acc_cnt_d = acc_cnt_q + ONE_CNT;
        end else begin
            acc_cnt_d = acc_cnt_q;
        end
    end

    // Flush pending: a repeat flush is absorbed, and an empty accumulator retires it silently
    always_comb begin
        if (xfer_s) begin
            flush_pend_d = 1'b0;
        end else if (flush_pend_q) begin
            flush_pend_d = (acc_cnt_q != ZERO_CNT);
        end else begin
            flush_pend_d = flush;
        end
    end

    // Output register: load on transfer, drop valid on accept, otherwise hold
    always_comb begin
        if (xfer_s) begin
            out_data_d  = beat_s;
            out_words_d = acc_cnt_q;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_data_d  = out_data_q;
            out_words_d = out_words_q;
            out_valid_d = 1'b0;
        end else begin
            out_data_d  = out_data_q;
            out_words_d = out_words_q;
            out_valid_d = out_valid_q;
        end
    end

    // State registers
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            acc_cnt_q    <= ZERO_CNT;
            acc_q        <= {(DSIZE*RATIO){1'b0}};
            flush_pend_q <= 1'b0;
            out_data_q   <= {(DSIZE*RATIO){1'b0}};
            out_words_q  <= ZERO_CNT;
            out_valid_q  <= 1'b0;
        end else begin
            acc_cnt_q    <= acc_cnt_d;
            acc_q        <= acc_d;
            flush_pend_q <= flush_pend_d;
            out_data_q   <= out_data_d;
            out_words_q  <= out_words_d;
            out_valid_q  <= out_valid_d;
        end
    end

    assign fifo_rinc = pop_s;
    assign out_data  = out_data_q;
    assign out_words = out_words_q;
    assign out_valid = out_valid_q;
    assign busy      = (acc_cnt_q != ZERO_CNT) || flush_pend_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Directed bench for fifo_rd_packer: a behavioural FIFO feeds the read port and every
// accepted beat is logged for comparison against hand-computed values.
module tb_fifo_rd_packer;

    logic        rclk;
    logic        rrst;
    logic [7:0]  fifo_rdata;
    logic        fifo_rempty;
    logic        fifo_rinc;
    logic        flush;
    logic [31:0] out_data;
    logic [3:0]  out_words;
    logic        out_valid;
    logic        out_ready;
    logic        busy;

    int vec_cnt = 0;
    int err_cnt = 0;

    logic [7:0]  mem [0:127];
    int          head = 0;
    int          tail = 0;
    int          pops = 0;
    int          bad_pops = 0;
    int          cyc = 0;
    logic [31:0] bd [0:31];
    logic [3:0]  bw [0:31];
    int          bc [0:31];
    int          bn = 0;

    fifo_rd_packer #(.DSIZE(8), .RATIO(4), .CNTW(4)) dut (
        .rclk(rclk), .rrst(rrst), .fifo_rdata(fifo_rdata), .fifo_rempty(fifo_rempty),
        .fifo_rinc(fifo_rinc), .flush(flush), .out_data(out_data), .out_words(out_words),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    assign fifo_rempty = (head == tail);
    assign fifo_rdata  = mem[head];

    always @(posedge rclk) begin
        cyc <= cyc + 1;
        if (!rrst && fifo_rinc) begin
            head <= head + 1;
            pops <= pops + 1;
            if (fifo_rempty) bad_pops <= bad_pops + 1;
        end
        if (!rrst && out_valid && out_ready) begin
            bd[bn] <= out_data;
            bw[bn] <= out_words;
            bc[bn] <= cyc;
            bn     <= bn + 1;
        end
    end

    task automatic push(input logic [7:0] v);
        mem[tail] = v;
        tail = tail + 1;
    endtask

    task automatic test_reset();
        rrst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge rclk);
        vec_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || fifo_rinc !== 1'b0) begin
            err_cnt++; $display("FAIL reset_ctl got valid=%b busy=%b rinc=%b exp 0 0 0", out_valid, busy, fifo_rinc);
        end
        vec_cnt++;
        if (out_data !== 32'h0 || out_words !== 4'd0) begin
            err_cnt++; $display("FAIL reset_data got %h/%0d exp 00000000/0", out_data, out_words);
        end
        rrst = 1'b0;
        @(negedge rclk);
    endtask

    task automatic test_single_beat();
        int base;
        base = bn;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        for (int i = 0; i < 4; i++) begin
            #1;
            vec_cnt++;
            if (fifo_rinc !== 1'b1) begin err_cnt++; $display("FAIL single_rinc[%0d] got %b exp 1", i, fifo_rinc); end
            @(negedge rclk);
        end
        #1;
        vec_cnt++;
        if (fifo_rinc !== 1'b0 || busy !== 1'b1) begin
            err_cnt++; $display("FAIL single_full got rinc=%b busy=%b exp 0 1", fifo_rinc, busy);
        end
        @(negedge rclk);
        vec_cnt++;
        if (out_valid !== 1'b1 || out_data !== 32'h44332211 || out_words !== 4'd4) begin
            err_cnt++; $display("FAIL single_beat got v=%b %h/%0d exp 1 44332211/4", out_valid, out_data, out_words);
        end
        @(negedge rclk);
        vec_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || bn - base !== 1) begin
            err_cnt++; $display("FAIL single_after got v=%b busy=%b beats=%0d exp 0 0 1", out_valid, busy, bn - base);
        end
    endtask

    task automatic test_stream();
        int base, p0;
        logic [31:0] exp_b [0:2];
        exp_b[0] = 32'h44332211; exp_b[1] = 32'h88776655; exp_b[2] = 32'hCCBBAA99;
        base = bn; p0 = pops;
        for (int i = 0; i < 12; i++) push(8'(8'h11 * (i + 1)));
        for (int i = 0; i < 12; i++) begin
            #1;
            vec_cnt++;
            if (fifo_rinc !== 1'b1) begin err_cnt++; $display("FAIL stream_rinc[%0d] got %b exp 1", i, fifo_rinc); end
            @(negedge rclk);
        end
        repeat (3) @(negedge rclk);
        vec_cnt++;
        if (pops - p0 !== 12 || bn - base !== 3) begin
            err_cnt++; $display("FAIL stream_counts got pops=%0d beats=%0d exp 12 3", pops - p0, bn - base);
        end
        for (int i = 0; i < 3; i++) begin
            vec_cnt++;
            if (bd[base+i] !== exp_b[i] || bw[base+i] !== 4'd4) begin
                err_cnt++; $display("FAIL stream_beat[%0d] got %h/%0d exp %h/4", i, bd[base+i], bw[base+i], exp_b[i]);
            end
        end
    endtask

    task automatic test_flush_partial();
        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (3) @(negedge rclk);
        flush = 1'b1;
        #1;
        vec_cnt++;
        if (fifo_rinc !== 1'b0 || busy !== 1'b1) begin
            err_cnt++; $display("FAIL flush_pre got rinc=%b busy=%b exp 0 1", fifo_rinc, busy);
        end
        @(negedge rclk);
        flush = 1'b0;
        #1;
        vec_cnt++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            err_cnt++; $display("FAIL flush_pend got busy=%b v=%b exp 1 0", busy, out_valid);
        end
        @(negedge rclk);
        vec_cnt++;
        if (out_valid !== 1'b1 || out_data !== 32'h00A3A2A1 || out_words !== 4'd3 || busy !== 1'b0) begin
            err_cnt++; $display("FAIL flush_beat got v=%b %h/%0d busy=%b exp 1 00A3A2A1/3 0", out_valid, out_data, out_words, busy);
        end
        @(negedge rclk);
        vec_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            err_cnt++; $display("FAIL flush_after got v=%b busy=%b exp 0 0", out_valid, busy);
        end
    endtask

    task automatic test_backpressure();
        int base, p0;
        out_ready = 1'b0;
        base = bn; p0 = pops;
        for (int i = 1; i <= 9; i++) push(8'(i));
        repeat (12) @(negedge rclk);
        #1;
        vec_cnt++;
        if (pops - p0 !== 8 || fifo_rinc !== 1'b0 || busy !== 1'b1) begin
            err_cnt++; $display("FAIL bp_stall got pops=%0d rinc=%b busy=%b exp 8 0 1", pops - p0, fifo_rinc, busy);
        end
        for (int i = 0; i < 2; i++) begin
            vec_cnt++;
            if (out_valid !== 1'b1 || out_data !== 32'h04030201 || out_words !== 4'd4) begin
                err_cnt++; $display("FAIL bp_hold[%0d] got v=%b %h/%0d exp 1 04030201/4", i, out_valid, out_data, out_words);
            end
            @(negedge rclk);
        end
        out_ready = 1'b1;
        repeat (2) @(negedge rclk);
        vec_cnt++;
        if (bn - base !== 2 || bd[base] !== 32'h04030201 || bd[base+1] !== 32'h08070605) begin
            err_cnt++; $display("FAIL bp_order got n=%0d %h %h exp 2 04030201 08070605", bn - base, bd[base], bd[base+1]);
        end
        vec_cnt++;
        if (bc[base+1] - bc[base] !== 1 || busy !== 1'b1) begin
            err_cnt++; $display("FAIL bp_b2b got gap=%0d busy=%b exp 1 1", bc[base+1] - bc[base], busy);
        end
        flush = 1'b1;
        @(negedge rclk);
        flush = 1'b0;
        repeat (3) @(negedge rclk);
        vec_cnt++;
        if (bn - base !== 3 || bd[base+2] !== 32'h00000009 || bw[base+2] !== 4'd1 || busy !== 1'b0) begin
            err_cnt++; $display("FAIL bp_tail got n=%0d %h/%0d busy=%b exp 3 00000009/1 0", bn - base, bd[base+2], bw[base+2], busy);
        end
    endtask

    task automatic test_flush_empty();
        int base;
        base = bn;
        flush = 1'b1;
        @(negedge rclk);
        flush = 1'b0;
        #1;
        vec_cnt++;
        if (busy !== 1'b1) begin err_cnt++; $display("FAIL fe_pend got busy=%b exp 1", busy); end
        @(negedge rclk);
        vec_cnt++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            err_cnt++; $display("FAIL fe_clear got busy=%b v=%b exp 0 0", busy, out_valid);
        end
        push(8'h55);
        flush = 1'b1;
        #1;
        vec_cnt++;
        if (fifo_rinc !== 1'b0) begin err_cnt++; $display("FAIL fe_coinc got rinc=%b exp 0", fifo_rinc); end
        @(negedge rclk);
        flush = 1'b0;
        #1;
        vec_cnt++;
        if (fifo_rinc !== 1'b0) begin err_cnt++; $display("FAIL fe_pendblk got rinc=%b exp 0", fifo_rinc); end
        @(negedge rclk);
        #1;
        vec_cnt++;
        if (fifo_rinc !== 1'b1 || bn !== base) begin
            err_cnt++; $display("FAIL fe_resume got rinc=%b beats=%0d exp 1 0", fifo_rinc, bn - base);
        end
        @(negedge rclk);
        push(8'h66); push(8'h77); push(8'h88);
        repeat (6) @(negedge rclk);
        vec_cnt++;
        if (bn - base !== 1 || bd[base] !== 32'h88776655 || bw[base] !== 4'd4) begin
            err_cnt++; $display("FAIL fe_beat got n=%0d %h/%0d exp 1 88776655/4", bn - base, bd[base], bw[base]);
        end
    endtask

    task automatic test_reset_mid();
        int base, p0;
        out_ready = 1'b0;
        p0 = pops;
        for (int i = 1; i <= 6; i++) push(8'(8'hE0 + i));
        repeat (8) @(negedge rclk);
        vec_cnt++;
        if (out_valid !== 1'b1 || busy !== 1'b1 || pops - p0 !== 6) begin
            err_cnt++; $display("FAIL rm_pre got v=%b busy=%b pops=%0d exp 1 1 6", out_valid, busy, pops - p0);
        end
        #2;
        rrst = 1'b1;
        #1;
        vec_cnt++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== 32'h0 || out_words !== 4'd0) begin
            err_cnt++; $display("FAIL rm_async got v=%b busy=%b %h/%0d exp 0 0 00000000/0", out_valid, busy, out_data, out_words);
        end
        push(8'hF1);
        #1;
        vec_cnt++;
        if (fifo_rinc !== 1'b0) begin err_cnt++; $display("FAIL rm_rinc got %b exp 0", fifo_rinc); end
        base = bn;
        @(negedge rclk);
        rrst = 1'b0;
        out_ready = 1'b1;
        push(8'hF2); push(8'hF3); push(8'hF4);
        repeat (7) @(negedge rclk);
        vec_cnt++;
        if (bn - base !== 1 || bd[base] !== 32'hF4F3F2F1 || bw[base] !== 4'd4) begin
            err_cnt++; $display("FAIL rm_beat got n=%0d %h/%0d exp 1 F4F3F2F1/4", bn - base, bd[base], bw[base]);
        end
        vec_cnt++;
        if (bad_pops !== 0 || busy !== 1'b0) begin
            err_cnt++; $display("FAIL rm_final got bad_pops=%0d busy=%b exp 0 0", bad_pops, busy);
        end
    endtask

    initial begin
        rrst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        @(negedge rclk);
        test_reset();
        test_single_beat();
        test_stream();
        test_flush_partial();
        test_backpressure();
        test_flush_empty();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
